snake_move_ctrl: RTL and testbench

SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

---
 rtl/snake_move_ctrl.sv | 168 ++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: synchronizes VGA vsync and buttons, paces head steps
// by frame count, and runs an IDLE/RUN/OVER game FSM with wall collision detection.
module snake_move_ctrl #(
  parameter int GRID_W      = 64,
  parameter int GRID_H      = 48,
  parameter int STEP_FRAMES = 6,
  parameter int START_X     = 32,
  parameter int START_Y     = 24
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iV_SYNC,
  input  logic       iUpButton,
  input  logic       iDownButton,
  input  logic       iLeftButton,
  input  logic       iRightButton,
  input  logic       iStart,
  output logic [5:0] oHead_X,
  output logic [5:0] oHead_Y,
  output logic [1:0] oDir,
  output logic       oMove_Pulse,
  output logic       oGame_Over,
  output logic [1:0] oState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [5:0] START_X_C = 6'(START_X);
  localparam logic [5:0] START_Y_C = 6'(START_Y);
  localparam logic [5:0] X_MAX     = 6'(GRID_W - 1);
  localparam logic [5:0] Y_MAX     = 6'(GRID_H - 1);
  localparam logic [5:0] STEP_LAST = 6'(STEP_FRAMES - 1);

  // Bit 4 is vsync, bits 3..0 are up/down/left/right.
  logic [4:0] sync1_q, sync1_d;
  logic [4:0] sync2_q, sync2_d;
  logic       vs_prev_q, vs_prev_d;

  state_t     state_q, state_d;
  logic [5:0] head_x_q, head_x_d;
  logic [5:0] head_y_q, head_y_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] pend_q, pend_d;
  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic       move_pulse_q, move_pulse_d;

  logic       frame_tick;
  logic       req_valid;
  logic [1:0] req_dir;
  logic       hit_wall;

  always_comb begin
    sync1_d    = {iV_SYNC, iUpButton, iDownButton, iLeftButton, iRightButton};
    sync2_d    = sync1_q;
    vs_prev_d  = sync2_q[4];
    frame_tick = sync2_q[4] & ~vs_prev_q;
  end

  // Highest-priority pressed button forms the request; a reversal of it is dropped, not demoted.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (sync2_q[3])      req_dir = DIR_UP;
    else if (sync2_q[2]) req_dir = DIR_DOWN;
    else if (sync2_q[1]) req_dir = DIR_LEFT;
    else if (sync2_q[0]) req_dir = DIR_RIGHT;
    else                 req_valid = 1'b0;
  end

  always_comb begin
    hit_wall = 1'b0;
    case (pend_q)
      DIR_UP:    hit_wall = (head_y_q == 6'd0);
      DIR_DOWN:  hit_wall = (head_y_q == Y_MAX);
      DIR_LEFT:  hit_wall = (head_x_q == 6'd0);
      default:   hit_wall = (head_x_q == X_MAX);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    dir_d        = dir_q;
    pend_d       = pend_q;
    frame_cnt_d  = frame_cnt_q;
    move_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (iStart) begin
          state_d     = ST_RUN;
          head_x_d    = START_X_C;
          head_y_d    = START_Y_C;
          dir_d       = DIR_RIGHT;
          pend_d      = DIR_RIGHT;
          frame_cnt_d = 6'd0;
        end
      end
      ST_RUN: begin
        if (req_valid && (req_dir != {dir_q[1], ~dir_q[0]})) pend_d = req_dir;
        // The step uses the pending direction from before this cycle's button sample.
        if (frame_tick) begin
          if (frame_cnt_q == STEP_LAST) begin
            frame_cnt_d = 6'd0;
            dir_d       = pend_q;
            if (hit_wall) begin
              state_d = ST_OVER;
            end else begin
              move_pulse_d = 1'b1;
              case (pend_q)
                DIR_UP:   head_y_d = head_y_q - 6'd1;
                DIR_DOWN: head_y_d = head_y_q + 6'd1;
                DIR_LEFT: head_x_d = head_x_q - 6'd1;
                default:  head_x_d = head_x_q + 6'd1;
              endcase
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      vs_prev_q    <= 1'b0;
      state_q      <= ST_IDLE;
      head_x_q     <= START_X_C;
      head_y_q     <= START_Y_C;
      dir_q        <= DIR_RIGHT;
      pend_q       <= DIR_RIGHT;
      frame_cnt_q  <= 6'd0;
      move_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      vs_prev_q    <= vs_prev_d;
      state_q      <= state_d;
      head_x_q     <= head_x_d;
      head_y_q     <= head_y_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      frame_cnt_q  <= frame_cnt_d;
      move_pulse_q <= move_pulse_d;
    end
  end

  assign oHead_X     = head_x_q;
  assign oHead_Y     = head_y_q;
  assign oDir        = dir_q;
  assign oMove_Pulse = move_pulse_q;
  assign oState      = state_q;
  assign oGame_Over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboarded bench for snake_move_ctrl: a frame-level game model predicts each head
// move, game start and game over; a monitor compares them as the DUT shows them.
module tb_snake_move_ctrl;
  localparam int STEP = 6;
  localparam int GW   = 64;
  localparam int GH   = 48;
  localparam int SX   = 32;
  localparam int SY   = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b1;
  logic up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0;
  logic start = 1'b0;
  logic [5:0] head_x, head_y;
  logic [1:0] dir, state;
  logic       move_pulse, game_over;

  always #5 clk = ~clk;

  snake_move_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .STEP_FRAMES(STEP), .START_X(SX), .START_Y(SY)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iV_SYNC(vs),
    .iUpButton(up), .iDownButton(dn), .iLeftButton(lf), .iRightButton(rt),
    .iStart(start),
    .oHead_X(head_x), .oHead_Y(head_y), .oDir(dir),
    .oMove_Pulse(move_pulse), .oGame_Over(game_over), .oState(state)
  );

  typedef struct { int st; int x; int y; int d; int p; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Game model: state 0 idle / 1 run / 2 over, directions 0 up 1 down 2 left 3 right.
  int m_st = 0, m_x = SX, m_y = SY, m_dir = 3, m_pend = 3, m_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int next_pend(input int p, input logic [3:0] b, input int d);
    int r;
    if (b[3])      r = 0;
    else if (b[2]) r = 1;
    else if (b[1]) r = 2;
    else if (b[0]) r = 3;
    else return p;
    if ((r == 0 && d == 1) || (r == 1 && d == 0) || (r == 2 && d == 3) || (r == 3 && d == 2))
      return p;
    return r;
  endfunction

  task automatic model_tick(input logic [3:0] b);
    int nx, ny;
    if (m_st != 1) return;
    m_pend = next_pend(m_pend, b, m_dir);
    if (m_cnt != STEP - 1) begin
      m_cnt++;
      return;
    end
    m_cnt = 0;
    nx = m_x + (m_pend == 3 ? 1 : 0) - (m_pend == 2 ? 1 : 0);
    ny = m_y + (m_pend == 1 ? 1 : 0) - (m_pend == 0 ? 1 : 0);
    m_dir = m_pend;
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      m_st = 2;
      exp_q.push_back('{2, m_x, m_y, m_dir, 0});
    end else begin
      m_x = nx;
      m_y = ny;
      exp_q.push_back('{1, m_x, m_y, m_dir, 1});
    end
    m_pend = next_pend(m_pend, b, m_dir);
  endtask

  // One video frame: buttons held throughout, optional iStart, then a vsync rising edge.
  task automatic frame(input logic [3:0] b, input bit do_start);
    @(posedge clk); #1;
    {up, dn, lf, rt} = b;
    vs = 1'b0;
    if (m_st == 1) m_pend = next_pend(m_pend, b, m_dir);
    repeat (4) @(posedge clk);
    #1;
    if (do_start) begin
      start = 1'b1;
      if (m_st != 1) begin
        m_st = 1; m_x = SX; m_y = SY; m_dir = 3; m_pend = 3; m_cnt = 0;
        exp_q.push_back('{1, SX, SY, 3, 0});
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (m_st == 1) m_pend = next_pend(m_pend, b, m_dir);
    end
    repeat (2) @(posedge clk);
    #1;
    vs = 1'b1;
    model_tick(b);
    repeat (8) @(posedge clk);
  endtask

  task automatic check_outputs(input string tag, input int st, input int x, input int y, input int d);
    check({tag, "_state"}, int'(state), st);
    check({tag, "_x"}, int'(head_x), x);
    check({tag, "_y"}, int'(head_y), y);
    check({tag, "_dir"}, int'(dir), d);
    check({tag, "_over"}, int'(game_over), (st == 2) ? 1 : 0);
  endtask

  // Monitor: every move pulse or state change must match the next expected event.
  initial begin
    int prev_st;
    exp_t e;
    prev_st = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_st = 0;
      end else if (move_pulse || int'(state) != prev_st) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: pulse=%0d state=%0d head=(%0d,%0d) dir=%0d, nothing required",
                   move_pulse, state, head_x, head_y, dir);
        end else begin
          e = exp_q.pop_front();
          check("ev_state", int'(state), e.st);
          check("ev_x", int'(head_x), e.x);
          check("ev_y", int'(head_y), e.y);
          check("ev_dir", int'(dir), e.d);
          check("ev_pulse", int'(move_pulse), e.p);
          check("ev_over", int'(game_over), (e.st == 2) ? 1 : 0);
        end
        prev_st = int'(state);
      end
    end
  end

  initial begin
    int guard;
    logic [3:0] b;
    bit st;

    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 0, SX, SY, 3);
    check("reset_pulse", int'(move_pulse), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Start, then one step right with no buttons.
    frame(4'b0000, 1'b1);
    for (int i = 0; i < STEP; i++) frame(4'b0000, 1'b0);
    check_outputs("first_step", 1, SX + 1, SY, 3);

    // Left while moving right is ignored; then up; then left; then up+right while moving left.
    for (int i = 0; i < STEP; i++) frame(4'b0010, 1'b0);
    check("reverse_ignored_dir", int'(dir), 3);
    for (int i = 0; i < STEP; i++) frame(4'b1000, 1'b0);
    check_outputs("turn_up", 1, SX + 2, SY - 1, 0);
    for (int i = 0; i < STEP; i++) frame(4'b0010, 1'b0);
    for (int i = 0; i < STEP; i++) frame(4'b1001, 1'b1);
    check_outputs("up_priority", 1, SX + 1, SY - 2, 0);

    // Reset in the cycle a step is due: no pulse, reset values, IDLE until iStart.
    guard = 0;
    while (m_cnt != STEP - 1 && guard < 2 * STEP) begin
      frame(4'b0000, 1'b0);
      guard++;
    end
    check("reset_step_due", m_cnt, STEP - 1);
    @(posedge clk); #1;
    {up, dn, lf, rt} = 4'b0000;
    vs = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vs = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs("mid_step_reset", 0, SX, SY, 3);
    check("mid_step_reset_pulse", int'(move_pulse), 0);
    m_st = 0; m_x = SX; m_y = SY; m_dir = 3; m_pend = 3; m_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < STEP + 2; i++) frame(4'b0100, 1'b0);
    check_outputs("idle_after_reset", 0, SX, SY, 3);

    // Run right into the east wall.
    frame(4'b0000, 1'b1);
    for (int i = 0; i < (GW - 1 - SX) * STEP; i++) frame(4'b0000, 1'b0);
    check_outputs("at_wall", 1, GW - 1, SY, 3);
    for (int i = 0; i < STEP; i++) frame(4'b0000, 1'b0);
    check_outputs("wall_hit", 2, GW - 1, SY, 3);
    for (int i = 0; i < STEP; i++) frame(4'b1000, 1'b0);
    check_outputs("over_holds", 2, GW - 1, SY, 3);
    frame(4'b0000, 1'b1);
    check_outputs("restart", 1, SX, SY, 3);

    // Random play with occasional restarts, including iStart while running.
    for (int i = 0; i < 1200; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      st = (m_st != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
      frame(b, st);
    end

    repeat (10) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
